noise_channel: RTL
==================

// Module: noise_channel
// PURPOSE
// - APU noise voice; consumer of the pRandomNum 8-bit pseudo-random stream.
// - Drives the generator's enable, samples its output on timer expiry, gates it with
//   length counter and envelope, and emits a 4-bit sample to the APU mixer.
// - Register-programmed by the APU bus decoder; frame sequencer supplies quarter/half ticks.
// PARAMETERS
// - CLK_DIV  16  clk cycles per timer tick (APU clock prescale), >=1
// PORTS
// - clk          in   1  system clock
// - rst_n        in   1  asynchronous active-low reset
// - reg_wr       in   1  register write strobe, single cycle
// - reg_addr     in   2  0:envelope 1:enable 2:period 3:length
// - reg_wdata    in   8  write data
// - quarter_frame in  1  envelope clock pulse, single cycle
// - half_frame   in   1  length clock pulse, single cycle
// - rnd_data     in   8  pRandomNum.dataO
// - rnd_enable   out  1  to pRandomNum.enable (low = reseed to 19)
// - sample       out  4  mixer sample
// - active       out  1  length counter != 0
// BEHAVIOUR
// - Reset: all regs 0; sample=0, active=0, rnd_enable=0, noise_bit=0, prescale=0, timer=0.
// - Reg0: [5]=halt/loop, [4]=const_vol, [3:0]=V. Reg1: [0]=ch_en. Reg2: [3:0]=period idx,
//   [7]=short mode (see CONFIGURATION). Reg3: [7:3]=len idx; write loads length=(idx+1)*2
//   (2..64) only if ch_en=1, and sets env_start.
// - rnd_enable = ch_en (registered, 1-cycle lag after reg1 write).
// - Prescaler: counts 0..CLK_DIV-1; tick on wrap. On tick: timer==0 -> reload
//   PERIOD[idx]-1, latch noise_bit=rnd_data[0]; else timer-=1.
// - PERIOD = {4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068}; timer 12 bits.
// - Period write does not reload timer; takes effect at next expiry.
// - Envelope on quarter_frame: env_start -> clear start, decay=15, div=V; else div==0 ->
//   div=V, decay>0 ? decay-1 : (loop ? 15 : 0); else div-=1.
// - Length on half_frame: !halt && length>0 -> length-1; saturates at 0.
// - sample (registered, 1-cycle latency) = 0 if !ch_en | length==0 | noise_bit==0;
//   else const_vol ? V : decay.
// - Reg1 write ch_en=0: length=0 immediately, rnd_enable falls next cycle (LFSR reseeds).
// - Reg3 write coincident with half_frame: load wins, no decrement that cycle.
// - Reg3 write coincident with quarter_frame: env_start set; envelope acts next quarter.
// - Reg0 write mid-decay: new V used at next divider reload; decay unchanged.
// - rst_n assertion mid-operation: all state cleared asynchronously, regardless of pulses.
// CONFIGURATION
// - NOISE_SHORT_MODE_EN defined: reg2[7]=1 counts timer expiries mod 8; on 8th expiry
//   rnd_enable driven low for exactly one clk (forces reseed) -> periodic metallic tone.
//   reg2[7]=0 behaves as undefined case.
// - Undefined: reg2[7] stored but ignored; expiry counter absent; rnd_enable = ch_en only.
// TESTING
// - Reset: rst_n=0 mid-run -> sample=0, active=0, rnd_enable=0 within same cycle (async).
// - Enable+length: reg1=0x01, reg3=0x08 (idx1) -> active=1, length=4; 4 half_frames
//   with halt=0 -> active=0 after 4th, sample=0.
// - Const volume: reg0=0x3A, idx0, CLK_DIV=16 -> sample in {0,0xA} tracking rnd_data[0]
//   latched every 64 clks; halt holds length through 100 half_frames.
// - Envelope: reg0=0x01, reg3 write, quarter_frames -> decay 15,15,14,14,...,0 then holds
//   0; with reg0=0x21 wraps 0->15.
// - Disable: reg1=0x00 while active -> active=0 next cycle, rnd_enable low, pRandomNum
//   dataO returns 19; reg3 write while disabled -> length stays 0.
// - Collision: reg3 write on same cycle as half_frame -> length=(idx+1)*2 exactly.

Source files
------------

// File: rtl/noise_channel.sv
// APU noise voice: samples the pseudo-random stream on timer expiry, gates it with length/envelope.
// Optional periodic reseed tone enabled by defining NOISE_SHORT_MODE_EN.
module noise_channel #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reg_wr,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       quarter_frame,
    input  logic       half_frame,
    input  logic [7:0] rnd_data,
    output logic       rnd_enable,
    output logic [3:0] sample,
    output logic       active
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);

    function automatic logic [11:0] period_of(input logic [3:0] idx);
        case (idx)
            4'd0:    period_of = 12'd4;
            4'd1:    period_of = 12'd8;
            4'd2:    period_of = 12'd16;
            4'd3:    period_of = 12'd32;
            4'd4:    period_of = 12'd64;
            4'd5:    period_of = 12'd96;
            4'd6:    period_of = 12'd128;
            4'd7:    period_of = 12'd160;
            4'd8:    period_of = 12'd202;
            4'd9:    period_of = 12'd254;
            4'd10:   period_of = 12'd380;
            4'd11:   period_of = 12'd508;
            4'd12:   period_of = 12'd762;
            4'd13:   period_of = 12'd1016;
            4'd14:   period_of = 12'd2034;
            default: period_of = 12'd4068;
        endcase
    endfunction

    logic [PW-1:0] prescale;
    logic [11:0]   timer;
    logic          halt;
    logic          const_vol;
    logic [3:0]    vol;
    logic          ch_en;
    logic [3:0]    period_idx;
    logic          short_mode;
    logic [6:0]    length;
    logic          env_start;
    logic [3:0]    decay;
    logic [3:0]    env_div;
    logic          noise_bit;

    logic          tick;
    logic          expire;
    logic          len_wr;
    logic          dis_wr;
    logic [6:0]    len_load;
    logic          reseed;
    logic          unused_bits;

`ifdef NOISE_SHORT_MODE_EN
    logic [2:0]    exp_cnt;
    assign reseed = expire && short_mode && (exp_cnt == 3'd7);
`else
    assign reseed = 1'b0;
`endif

    assign tick     = (prescale == PS_MAX);
    assign expire   = tick && (timer == '0);
    assign len_wr   = reg_wr && (reg_addr == 2'd3);
    assign dis_wr   = reg_wr && (reg_addr == 2'd1) && !reg_wdata[0];
    assign len_load = ({2'b00, reg_wdata[7:3]} + 7'd1) << 1;
    assign active   = (length != '0);
    assign unused_bits = ^{short_mode, reg_wdata[6], rnd_data[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale   <= '0;
            timer      <= '0;
            halt       <= 1'b0;
            const_vol  <= 1'b0;
            vol        <= '0;
            ch_en      <= 1'b0;
            period_idx <= '0;
            short_mode <= 1'b0;
            length     <= '0;
            env_start  <= 1'b0;
            decay      <= '0;
            env_div    <= '0;
            noise_bit  <= 1'b0;
            sample     <= '0;
            rnd_enable <= 1'b0;
`ifdef NOISE_SHORT_MODE_EN
            exp_cnt    <= '0;
`endif
        end else begin
            prescale <= tick ? '0 : prescale + 1'b1;
            if (tick) begin
                if (timer == '0) begin
                    timer     <= period_of(period_idx) - 12'd1;
                    noise_bit <= rnd_data[0];
                end else begin
                    timer <= timer - 12'd1;
                end
            end
`ifdef NOISE_SHORT_MODE_EN
            if (expire && short_mode)
                exp_cnt <= exp_cnt + 3'd1;
`endif

            // A length write on a quarter tick defers all envelope action to the next quarter.
            if (quarter_frame && !len_wr) begin
                if (env_start) begin
                    env_start <= 1'b0;
                    decay     <= 4'd15;
                    env_div   <= vol;
                end else if (env_div == '0) begin
                    env_div <= vol;
                    decay   <= (decay != '0) ? decay - 4'd1 : (halt ? 4'd15 : 4'd0);
                end else begin
                    env_div <= env_div - 4'd1;
                end
            end

            if (dis_wr)
                length <= '0;
            else if (len_wr) begin
                if (ch_en)
                    length <= len_load;
            end else if (half_frame && !halt && (length != '0))
                length <= length - 7'd1;

            if (reg_wr) begin
                case (reg_addr)
                    2'd0: begin
                        halt      <= reg_wdata[5];
                        const_vol <= reg_wdata[4];
                        vol       <= reg_wdata[3:0];
                    end
                    2'd1: ch_en <= reg_wdata[0];
                    2'd2: begin
                        period_idx <= reg_wdata[3:0];
                        short_mode <= reg_wdata[7];
                    end
                    default: env_start <= 1'b1;
                endcase
            end

            if (!ch_en || (length == '0) || !noise_bit)
                sample <= '0;
            else
                sample <= const_vol ? vol : decay;

            rnd_enable <= ch_en && !reseed;
        end
    end

endmodule
